// File: rtl/wbu_pipe.sv
// rtl/wbu_pipe.sv - write-back/commit unit: entry FIFO, next-PC/trap redirect, retire counter
// Entries commit in order from the FIFO head whenever the PCU is ready.
module wbu_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_res,
  input  logic [XLEN-1:0]  i_csrr_rd,
  input  logic [XLEN-1:0]  i_mepc,
  input  logic [XLEN-1:0]  i_mtvec,
  input  logic             i_wen,
  input  logic             i_csr_wen,
  input  logic             i_brch,
  input  logic             i_jal,
  input  logic             i_jalr,
  input  logic             i_csrr,
  input  logic             i_mret,
  input  logic             i_ecall,
  input  logic             i_pcu_ready,
  output logic             o_pc_update,
  output logic [XLEN-1:0]  o_pc_next,
  output logic [XLEN-1:0]  o_rd_wdata,
  output logic [XLEN-1:0]  o_csr_wdata,
  output logic             o_wbu_wen,
  output logic             o_wbu_csr_wen,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_retire_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] csrr_rd;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mtvec;
    logic            wen;
    logic            csr_wen;
    logic            brch;
    logic            jal;
    logic            jalr;
    logic            csrr;
    logic            mret;
    logic            ecall;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          in_e;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            push;
  logic            pop;

  assign in_e = '{pc: i_pc, rs1: i_rs1, imm: i_imm, res: i_res, csrr_rd: i_csrr_rd,
                  mepc: i_mepc, mtvec: i_mtvec, wen: i_wen, csr_wen: i_csr_wen,
                  brch: i_brch, jal: i_jal, jalr: i_jalr, csrr: i_csrr,
                  mret: i_mret, ecall: i_ecall};

  // Ready and commit are both forced low while reset is held.
  assign o_pre_ready = i_rst_n && (count != (PW+1)'(DEPTH));
  assign push        = i_pre_valid && o_pre_ready;
  assign o_pc_update = i_rst_n && (count != '0) && i_pcu_ready;
  assign pop         = o_pc_update;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_retire_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_e;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PW'(1);
        o_retire_cnt <= o_retire_cnt + CNT_W'(1);
      end
      if (push && !pop)
        count <= count + (PW+1)'(1);
      else if (!push && pop)
        count <= count - (PW+1)'(1);
    end
  end

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            xfer;
  logic            mis;

  always_comb begin
    pc4      = head.pc + XLEN'(4);
    pc_imm   = head.pc + head.imm;
    jalr_sum = head.rs1 + head.imm;
    taken    = head.brch && head.res[0];
    if (head.ecall)     target = head.mtvec;
    else if (head.mret) target = head.mepc;
    else if (head.jal)  target = pc_imm;
    else if (head.jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (taken)     target = pc_imm;
    else                target = pc4;
    // Only computed control transfers are alignment-checked; trap vectors are trusted.
    xfer = !head.ecall && !head.mret && (head.jal || head.jalr || taken);
    mis  = xfer && (target[1:0] != 2'b00);

    o_pc_next     = '0;
    o_rd_wdata    = '0;
    o_csr_wdata   = '0;
    o_wbu_wen     = 1'b0;
    o_wbu_csr_wen = 1'b0;
    o_misalign    = 1'b0;
    if (o_pc_update) begin
      o_pc_next     = mis ? head.mtvec : target;
      if (head.jal || head.jalr) o_rd_wdata = pc4;
      else if (head.csrr)        o_rd_wdata = head.csrr_rd;
      else                       o_rd_wdata = head.res;
      o_csr_wdata   = head.res;
      o_wbu_wen     = head.wen && !mis;
      o_wbu_csr_wen = head.csr_wen;
      o_misalign    = mis;
    end
  end

endmodule

// File: tb/tb_wbu_pipe.sv
// tb/tb_wbu_pipe.sv - self-checking bench for wbu_pipe with a queue-based reference model
module tb_wbu_pipe;
  localparam int XLEN = 32, DEPTH = 2, CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pre_valid, pre_ready, pcu_ready, pc_update, wbu_wen, wbu_csr_wen, misalign;
  logic [31:0] pc, rs1, imm, res, csrr_rd, mepc, mtvec, pc_next, rd_wdata, csr_wdata;
  logic        wen, csr_wen, brch, jal, jalr, csrr, mret, ecall;
  logic [7:0]  retire_cnt;

  wbu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
    .i_pc(pc), .i_rs1(rs1), .i_imm(imm), .i_res(res), .i_csrr_rd(csrr_rd),
    .i_mepc(mepc), .i_mtvec(mtvec), .i_wen(wen), .i_csr_wen(csr_wen),
    .i_brch(brch), .i_jal(jal), .i_jalr(jalr), .i_csrr(csrr), .i_mret(mret), .i_ecall(ecall),
    .i_pcu_ready(pcu_ready), .o_pc_update(pc_update), .o_pc_next(pc_next),
    .o_rd_wdata(rd_wdata), .o_csr_wdata(csr_wdata), .o_wbu_wen(wbu_wen),
    .o_wbu_csr_wen(wbu_csr_wen), .o_misalign(misalign), .o_retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [31:0] pc, rs1, imm, res, csrr_rd, mepc, mtvec;
    logic        wen, csr_wen, brch, jal, jalr, csrr, mret, ecall;
  } ent_t;

  ent_t       q[$];
  ent_t       cur;
  logic [7:0] mcnt;
  int         total = 0;
  int         bad = 0;

  function automatic ent_t rnd_ent(input int cls);
    ent_t e;
    e.pc = $urandom & 32'hFFFF_FFFC; e.rs1 = $urandom; e.imm = $urandom;
    if ($urandom % 2 == 0) e.imm = e.imm & 32'hFFFF_FFFC;
    e.res = $urandom; e.csrr_rd = $urandom; e.mepc = $urandom; e.mtvec = $urandom;
    e.wen = 1'($urandom); e.csr_wen = 1'($urandom);
    e.brch = (cls == 1); e.jal = (cls == 2); e.jalr = (cls == 3);
    e.csrr = (cls == 4); e.mret = (cls == 5); e.ecall = (cls == 6);
    return e;
  endfunction

  task automatic drive(input ent_t e, input logic v);
    cur = e; pre_valid = v;
    pc = e.pc; rs1 = e.rs1; imm = e.imm; res = e.res; csrr_rd = e.csrr_rd;
    mepc = e.mepc; mtvec = e.mtvec; wen = e.wen; csr_wen = e.csr_wen;
    brch = e.brch; jal = e.jal; jalr = e.jalr; csrr = e.csrr; mret = e.mret; ecall = e.ecall;
  endtask

  // Expected commit-output bundle derived from the model queue head.
  function automatic logic [99:0] expv();
    ent_t e; logic [31:0] t, rd; logic xfer, mis;
    if (!rst_n || !pcu_ready || q.size() == 0) return '0;
    e = q[0];
    if (e.ecall)                  t = e.mtvec;
    else if (e.mret)              t = e.mepc;
    else if (e.jal)               t = e.pc + e.imm;
    else if (e.jalr)              t = (e.rs1 + e.imm) & ~32'h1;
    else if (e.brch && e.res[0])  t = e.pc + e.imm;
    else                          t = e.pc + 32'd4;
    xfer = !e.ecall && !e.mret && (e.jal || e.jalr || (e.brch && e.res[0]));
    mis  = xfer && (t % 4 != 0);
    rd   = (e.jal || e.jalr) ? e.pc + 32'd4 : (e.csrr ? e.csrr_rd : e.res);
    return {1'b1, mis ? e.mtvec : t, rd, e.res, e.wen && !mis, e.csr_wen, mis};
  endfunction

  function automatic logic [99:0] gotv();
    return {pc_update, pc_next, rd_wdata, csr_wdata, wbu_wen, wbu_csr_wen, misalign};
  endfunction

  task automatic tick();
    logic upd, psh;
    upd = rst_n && pcu_ready && q.size() > 0;
    psh = rst_n && pre_valid && q.size() < DEPTH;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); mcnt = 8'd0;
    end else begin
      if (upd) begin q.delete(0); mcnt = mcnt + 8'd1; end
      if (psh) q.push_back(cur);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pre_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pcu_ready = 1'b1;
    drive(rnd_ent(0), 1'b1);
    tick(); tick();
    total++; if (pre_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", pre_ready); end
    total++; if (gotv() !== 100'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", gotv()); end
    total++; if (retire_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
    rst_n = 1'b1; pre_valid = 1'b0; #1;
    total++; if (pre_ready !== 1'b1 || pc_update !== 1'b0) begin bad++; $display("FAIL post_reset got=%b%b exp=10", pre_ready, pc_update); end
  endtask

  task automatic test_alu();
    ent_t e = rnd_ent(0);
    e.pc = 32'h8000_0000; e.res = 32'd5; e.wen = 1'b1; e.csr_wen = 1'b0;
    pcu_ready = 1'b1; drive(e, 1'b1); #1;
    total++; if (pc_update !== 1'b0) begin bad++; $display("FAIL alu_no_bypass got=%b exp=0", pc_update); end
    tick(); pre_valid = 1'b0; #1;
    total++; if (gotv() !== {1'b1, 32'h8000_0004, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0})
      begin bad++; $display("FAIL alu_commit got=%h", gotv()); end
    tick();
    total++; if (retire_cnt !== 8'd1) begin bad++; $display("FAIL alu_cnt got=%0d exp=1", retire_cnt); end
  endtask

  task automatic test_jumps();
    ent_t a = rnd_ent(2), b = rnd_ent(3);
    a.pc = 32'h100; a.imm = 32'h20;
    b.pc = 32'h300; b.rs1 = 32'h201; b.imm = 32'h0;
    pcu_ready = 1'b1; drive(a, 1'b1); tick();
    drive(b, 1'b1); #1;
    total++; if (pc_next !== 32'h120 || rd_wdata !== 32'h104 || misalign !== 1'b0)
      begin bad++; $display("FAIL jal got=%h/%h exp=120/104", pc_next, rd_wdata); end
    tick(); pre_valid = 1'b0; #1;
    total++; if (pc_next !== 32'h200 || rd_wdata !== 32'h304 || misalign !== 1'b0)
      begin bad++; $display("FAIL jalr got=%h/%h exp=200/304", pc_next, rd_wdata); end
    tick();
  endtask

  task automatic test_backpressure();
    ent_t a = rnd_ent(0), b = rnd_ent(0);
    a.pc = 32'h10; b.pc = 32'h40;
    pcu_ready = 1'b0;
    drive(a, 1'b1); tick(); drive(b, 1'b1); tick();
    drive(rnd_ent(0), 1'b1); #1;
    total++; if (pre_ready !== 1'b0 || pc_update !== 1'b0) begin bad++; $display("FAIL bp_full got=%b%b exp=00", pre_ready, pc_update); end
    pre_valid = 1'b0; pcu_ready = 1'b1; #1;
    total++; if (pc_update !== 1'b1 || pc_next !== 32'h14) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/14", pc_update, pc_next); end
    tick();
    total++; if (pc_update !== 1'b1 || pc_next !== 32'h44 || pre_ready !== 1'b1)
      begin bad++; $display("FAIL bp_second got=%b/%h/%b exp=1/44/1", pc_update, pc_next, pre_ready); end
    tick();
    total++; if (pc_update !== 1'b0 || pre_ready !== 1'b1) begin bad++; $display("FAIL bp_drained got=%b%b exp=01", pc_update, pre_ready); end
  endtask

  task automatic test_misalign();
    ent_t e = rnd_ent(2);
    logic [7:0] c;
    e.pc = 32'h100; e.imm = 32'h22; e.mtvec = 32'h400; e.wen = 1'b1;
    pcu_ready = 1'b1; drive(e, 1'b1); tick(); pre_valid = 1'b0; #1;
    total++; if (misalign !== 1'b1 || pc_next !== 32'h400 || wbu_wen !== 1'b0)
      begin bad++; $display("FAIL misalign got=%b/%h/%b exp=1/400/0", misalign, pc_next, wbu_wen); end
    c = mcnt + 8'd1;
    tick();
    total++; if (retire_cnt !== c) begin bad++; $display("FAIL misalign_cnt got=%0d exp=%0d", retire_cnt, c); end
  endtask

  task automatic test_full_pushpop();
    pcu_ready = 1'b0;
    drive(rnd_ent(0), 1'b1); tick(); drive(rnd_ent(1), 1'b1); tick();
    pcu_ready = 1'b1; drive(rnd_ent(2), 1'b1); #1;
    total++; if (pre_ready !== 1'b0 || gotv() !== expv()) begin bad++; $display("FAIL full_pop got=%b/%h exp=0/%h", pre_ready, gotv(), expv()); end
    tick(); drive(rnd_ent(3), 1'b1); #1;
    total++; if (pre_ready !== 1'b1 || gotv() !== expv()) begin bad++; $display("FAIL pushpop got=%b/%h exp=1/%h", pre_ready, gotv(), expv()); end
    tick(); pre_valid = 1'b0; #1;
    total++; if (gotv() !== expv()) begin bad++; $display("FAIL pushpop_order got=%h exp=%h", gotv(), expv()); end
    tick();
    pcu_ready = 1'b0;
    drive(rnd_ent(0), 1'b1); tick(); drive(rnd_ent(0), 1'b1); tick();
    rst_n = 1'b0; pcu_ready = 1'b1; pre_valid = 1'b0; #1;
    total++; if (pc_update !== 1'b0 || pre_ready !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b%b exp=00", pc_update, pre_ready); end
    tick(); rst_n = 1'b1; #1;
    total++; if (pc_update !== 1'b0 || retire_cnt !== 8'd0 || pre_ready !== 1'b1)
      begin bad++; $display("FAIL rst_mid got=%b/%0d/%b exp=0/0/1", pc_update, retire_cnt, pre_ready); end
  endtask

  task automatic test_traps();
    ent_t a = rnd_ent(6), b = rnd_ent(5);
    a.mtvec = 32'h80; b.mepc = 32'h1234;
    pcu_ready = 1'b1; drive(a, 1'b1); tick(); drive(b, 1'b1); #1;
    total++; if (pc_next !== 32'h80 || misalign !== 1'b0) begin bad++; $display("FAIL ecall got=%h exp=80", pc_next); end
    tick(); pre_valid = 1'b0; #1;
    total++; if (pc_next !== 32'h1234 || misalign !== 1'b0) begin bad++; $display("FAIL mret got=%h exp=1234", pc_next); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pcu_ready = ($urandom % 4) != 0;
      drive(rnd_ent($urandom % 7), ($urandom % 3) != 0); #1;
      total++; if (gotv() !== expv()) begin bad++; $display("FAIL rnd_out i=%0d got=%h exp=%h", i, gotv(), expv()); end
      total++; if (pre_ready !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready i=%0d got=%b", i, pre_ready); end
      total++; if (retire_cnt !== mcnt) begin bad++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, retire_cnt, mcnt); end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    pcu_ready = 1'b1;
    for (int i = 0; i < 600 && mcnt != 8'hFF; i++) begin
      drive(rnd_ent($urandom % 7), 1'b1); tick();
    end
    #1;
    total++; if (retire_cnt !== 8'hFF || pc_update !== 1'b1)
      begin bad++; $display("FAIL wrap_pre got=%0d/%b exp=255/1", retire_cnt, pc_update); end
    pre_valid = 1'b0; tick();
    total++; if (retire_cnt !== 8'd0) begin bad++; $display("FAIL wrap got=%0d exp=0", retire_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; pcu_ready = 1'b0; mcnt = 8'd0;
    drive(rnd_ent(0), 1'b0);
    test_reset();
    test_alu();
    test_jumps();
    test_backpressure();
    test_misalign();
    test_full_pushpop();
    test_traps();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
